// File: rtl/list_cache_pkg.sv
// Shared sizing helpers, replay mode encoding and header field positions for the list cache.
package list_cache_pkg;

  typedef enum logic {
    MODE_STREAM = 1'b0,
    MODE_LOOP   = 1'b1
  } mode_e;

  // Sequence toggle lives in bit 0 of header word 0.
  localparam int HDR_TOG_BIT = 0;

  function automatic int ts_of(input int fs);
    return fs - 1;
  endfunction

  function automatic int slot_w(input int bs);
    return (bs > 2) ? $clog2(bs) : 1;
  endfunction

  function automatic int idx_w(input int ts);
    return (ts > 2) ? $clog2(ts) : 1;
  endfunction

  function automatic int level_w(input int bs);
    return $clog2(bs) + 1;
  endfunction

endpackage

// File: rtl/list_line_ring.sv
// Line storage: full-line write port, combinational element read port (slot, index).
// No reset on storage; validity is tracked by the owner's pointers.
module list_line_ring #(
  parameter int DW = 32,
  parameter int TS = 7,
  parameter int BS = 2,
  parameter int SW = 1,
  parameter int IW = 3
) (
  input  logic              CLK,
  input  logic              i_wr_en,
  input  logic [SW-1:0]     i_wr_slot,
  input  logic [TS*DW-1:0]  i_wr_line,
  input  logic [SW-1:0]     i_rd_slot,
  input  logic [IW-1:0]     i_rd_idx,
  output logic [DW-1:0]     o_rd_dat
);

  logic [TS-1:0][DW-1:0] r_mem [BS];

  always_ff @(posedge CLK) begin
    if (i_wr_en) r_mem[i_wr_slot] <= i_wr_line;
  end

  assign o_rd_dat = r_mem[i_rd_slot][i_rd_idx];

endmodule

// File: rtl/list_stream_cache.sv
// Deduplicating list cache: lines in, one element per cycle out through a registered output stage.
// Accept to first element is 2 cycles; IN_READY drops while BS lines are held, output holds under !OUT_READY.
module list_stream_cache
  import list_cache_pkg::*;
#(
  parameter int DW = 32,
  parameter int FS = 8,
  parameter int BS = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FLUSH,
  input  logic                LOOP,
  input  logic [FS*DW-1:0]    IN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [DW-1:0]       OUT,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [$clog2(BS):0] LEVEL
);

  localparam int TS = ts_of(FS);
  localparam int SW = slot_w(BS);
  localparam int IW = idx_w(TS);
  localparam int LW = level_w(BS);

  logic [SW-1:0] r_wr_slot;
  logic [SW-1:0] r_rd_slot;
  logic [IW-1:0] r_rd_idx;
  logic [LW-1:0] r_level;
  mode_e         r_mode;
  logic          r_tog_seen;
  logic          r_last_tog;
  logic          r_in_ready;
  logic [DW-1:0] r_out;
  logic          r_out_valid;
  logic          r_out_last;

  logic          w_tog;
  logic          w_acc;
  logic          w_wr;
  logic          w_rd_last;
  logic [LW-1:0] w_pending;
  logic          w_avail;
  logic          w_load;
  logic          w_free;
  logic [LW-1:0] w_level_nxt;
  logic [DW-1:0] w_rd_dat;
  logic          w_unused_hdr;

  assign w_tog        = IN[HDR_TOG_BIT];
  assign w_unused_hdr = ^IN[DW-1:1];
  assign w_acc        = IN_VALID && r_in_ready;
  assign w_wr         = w_acc && (!r_tog_seen || (w_tog != r_last_tog));
  assign w_rd_last    = (r_rd_idx == IW'(TS - 1));

  // A line whose last element already sits in the output stage has nothing left to read.
  assign w_pending   = r_level - LW'(r_out_valid && r_out_last);
  assign w_avail     = (r_mode == MODE_LOOP) ? (r_level == LW'(BS)) : (w_pending != '0);
  assign w_load      = w_avail && (!r_out_valid || OUT_READY);
  assign w_free      = (r_mode == MODE_STREAM) && r_out_valid && OUT_READY && r_out_last;
  assign w_level_nxt = r_level + LW'(w_wr) - LW'(w_free);

  list_line_ring #(
    .DW(DW),
    .TS(TS),
    .BS(BS),
    .SW(SW),
    .IW(IW)
  ) u_ring (
    .CLK       (CLK),
    .i_wr_en   (w_wr && !FLUSH && !RESET),
    .i_wr_slot (r_wr_slot),
    .i_wr_line (IN[FS*DW-1:DW]),
    .i_rd_slot (r_rd_slot),
    .i_rd_idx  (r_rd_idx),
    .o_rd_dat  (w_rd_dat)
  );

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_rd_idx    <= '0;
      r_level     <= '0;
      r_tog_seen  <= 1'b0;
      r_last_tog  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (RESET) r_mode <= MODE_STREAM;
    end else begin
      if (r_level == '0) r_mode <= mode_e'(LOOP);
      r_level    <= w_level_nxt;
      r_in_ready <= (w_level_nxt < LW'(BS));
      if (w_wr) begin
        r_wr_slot  <= r_wr_slot + SW'(1);
        r_tog_seen <= 1'b1;
        r_last_tog <= w_tog;
      end
      if (w_load) begin
        r_out       <= w_rd_dat;
        r_out_valid <= 1'b1;
        r_out_last  <= w_rd_last;
        r_rd_idx    <= w_rd_last ? '0 : r_rd_idx + IW'(1);
        if (w_rd_last) r_rd_slot <= r_rd_slot + SW'(1);
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;
  assign LEVEL     = r_level;

endmodule

// File: tb/tb_list_stream_cache.sv
// Directed scoreboard bench for list_stream_cache (DW=32, FS=8, BS=2).
module tb_list_stream_cache;

  localparam int DW = 32;
  localparam int FS = 8;
  localparam int BS = 2;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               FLUSH = 1'b0;
  logic               LOOP = 1'b0;
  logic [FS*DW-1:0]   IN = '0;
  logic               IN_VALID = 1'b0;
  logic               IN_READY;
  logic [DW-1:0]      OUT;
  logic               OUT_VALID;
  logic               OUT_READY = 1'b0;
  logic [$clog2(BS):0] LEVEL;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  always #5 CLK = ~CLK;

  list_stream_cache #(.DW(DW), .FS(FS), .BS(BS)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .LOOP      (LOOP),
    .IN        (IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OUT       (OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .LEVEL     (LEVEL)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Scoreboard monitor: every output handshake must match the next expected element.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL out_unexpected: got %0d, want no element", OUT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (OUT !== mon_exp) begin
          n_errors++;
          $display("FAIL out_data: got %0d, want %0d", OUT, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [FS*DW-1:0] mk_line(input logic tog, input int base);
    logic [FS*DW-1:0] l;
    l = '0;
    l[0] = tog;
    for (int w = 1; w < FS; w++) l[w*DW +: DW] = DW'(base + w - 1);
    return l;
  endfunction

  task automatic push_range(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q.push_back(DW'(v));
  endtask

  task automatic send_line(input logic tog, input int base, input bit keep);
    int g;
    IN = mk_line(tog, base);
    IN_VALID = 1'b1;
    g = 0;
    while (!IN_READY && g < 60) begin
      step();
      g++;
    end
    chk("in_accept", IN_READY, 1);
    if (keep) push_range(base, base + FS - 2);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      step();
      g++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_valid_off"}, OUT_VALID, 0);
    chk({name, "_level_zero"}, LEVEL, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int bubbles;
    bit saw_ready;

    // Reset state
    step();
    step();
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_out", OUT, 0);
    RESET = 1'b0;
    step();
    chk("post_rst_in_ready", IN_READY, 1);

    // Stream basic with latency and no-bubble checks
    OUT_READY = 1'b1;
    send_line(1'b0, 1, 1'b1);
    chk("lat_t1_valid", OUT_VALID, 0);
    chk("lat_t1_level", LEVEL, 1);
    step();
    chk("lat_t2_valid", OUT_VALID, 1);
    chk("lat_t2_out", OUT, 1);
    send_line(1'b1, 8, 1'b1);
    bubbles = 0;
    for (int i = 0; i < 12; i++) begin
      if (!OUT_VALID) bubbles++;
      step();
    end
    chk("stream_bubbles", bubbles, 0);
    wait_drain("stream");

    // Dedupe: repeated toggle is handshaken and dropped
    send_line(1'b0, 1, 1'b1);
    send_line(1'b0, 99, 1'b0);
    wait_drain("dedupe");

    // Backpressure: two lines held, output frozen
    OUT_READY = 1'b0;
    send_line(1'b1, 1, 1'b1);
    send_line(1'b0, 8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_frozen", OUT_VALID ? OUT : 32'hDEAD, 1);
      step();
    end
    chk("bp_in_ready", IN_READY, 0);
    chk("bp_level", LEVEL, 2);
    OUT_READY = 1'b1;
    wait_drain("bp");

    // Full/free collision: no same-cycle bypass
    OUT_READY = 1'b0;
    send_line(1'b1, 1, 1'b1);
    send_line(1'b0, 8, 1'b1);
    chk("coll_level_full", LEVEL, 2);
    IN = mk_line(1'b1, 15);
    IN_VALID = 1'b1;
    push_range(15, 21);
    OUT_READY = 1'b1;
    g = 0;
    while (!(OUT_VALID && OUT == 7) && g < 30) begin
      step();
      g++;
    end
    chk("coll_found_7", OUT, 7);
    chk("coll_pop_in_ready", IN_READY, 0);
    chk("coll_pop_level", LEVEL, 2);
    step();
    chk("coll_next_in_ready", IN_READY, 1);
    chk("coll_next_level", LEVEL, 1);
    step();
    IN_VALID = 1'b0;
    chk("coll_after_level", LEVEL, 2);
    chk("coll_after_in_ready", IN_READY, 0);
    wait_drain("coll");

    // Loop mode: replay starts only when full, wraps forever
    LOOP = 1'b1;
    step();
    send_line(1'b0, 1, 1'b0);
    chk("loop_one_line_idle", OUT_VALID, 0);
    send_line(1'b1, 8, 1'b0);
    chk("loop_full_idle", OUT_VALID, 0);
    chk("loop_full_in_ready", IN_READY, 0);
    for (int p = 0; p < 4; p++) push_range(1, 14);
    saw_ready = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      if (IN_READY) saw_ready = 1'b1;
      step();
      g++;
    end
    OUT_READY = 1'b0;
    chk("loop_drained", exp_q.size(), 0);
    chk("loop_in_ready_stays_low", saw_ready, 0);
    chk("loop_level", LEVEL, 2);
    chk("loop_still_valid", OUT_VALID, 1);
    chk("loop_wrapped_to_1", OUT, 1);
    FLUSH = 1'b1;
    LOOP = 1'b0;
    step();
    FLUSH = 1'b0;
    chk("loop_flush_valid", OUT_VALID, 0);
    chk("loop_flush_level", LEVEL, 0);
    step();

    // Flush mid-list, then same toggle accepted as first line
    OUT_READY = 1'b1;
    send_line(1'b0, 1, 1'b0);
    push_range(1, 4);
    g = 0;
    while (!(OUT_VALID && OUT == 5) && g < 30) begin
      step();
      g++;
    end
    chk("flush_found_5", OUT, 5);
    OUT_READY = 1'b0;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("flush_valid", OUT_VALID, 0);
    chk("flush_level", LEVEL, 0);
    chk("flush_q_empty", exp_q.size(), 0);
    OUT_READY = 1'b1;
    send_line(1'b0, 50, 1'b1);
    wait_drain("post_flush");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
